fp32_addsub_issue: RTL and testbench

Operand issue/collect stage wrapped around the registered FP32 add/sub unit (1-cycle registered result, no stall input, no reset).
- Accepts operand pairs and command over a valid/ready handshake and buffers them in an input FIFO.
- Drives the adder one op per cycle under credit control, so results are never dropped.
- Collects adder results into an output FIFO with tag, and presents them downstream with valid/ready.

---
 rtl/fp32_addsub_issue.sv | 242 ++++++++++++++++++++++++
 tb/tb_fp32_addsub_issue.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_addsub_issue.sv
// fp32_addsub_issue: operand issue/collect stage around a registered FP32 add/sub unit.
// Operands are buffered in an input FIFO and issued one per cycle under credit
// control. Results are collected with their tags into an output FIFO and
// presented downstream over valid/ready.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               operand handshake (in_ready registered)
//   in_a, in_b, in_cmd, in_tag      operands, 1 = add / 0 = sub (A-B), user tag
//   fpu_add1/fpu_add2/fpu_command   registered operands/command to the adder
//   fpu_result                      adder registered result (LAT cycles after issue)
//   out_valid/out_ready             result handshake
//   out_result, out_tag             registered output FIFO head
//   busy                            any op buffered, in flight or unread
//
// Optional feature macro: FP32_SPECIAL_BYPASS_EN
//   Classifies NaN/Inf operands at issue and substitutes the IEEE special
//   result for the adder output at capture.
module fp32_addsub_issue #(
  parameter int unsigned IN_DEPTH  = 4,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned LAT       = 1,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_cmd,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      fpu_add1,
  output logic [31:0]      fpu_add2,
  output logic             fpu_command,
  input  logic [31:0]      fpu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned IAW = $clog2(IN_DEPTH);
  localparam int unsigned IPW = IAW + 1;
  localparam int unsigned OAW = $clog2(OUT_DEPTH);
  localparam int unsigned OPW = OAW + 1;
  localparam int unsigned EW  = 65 + TAG_W;
  localparam int unsigned OW  = 32 + TAG_W;
  localparam int unsigned CW  = $clog2(OUT_DEPTH + LAT + 2) + 1;

  // Input FIFO
  logic [EW-1:0]    r_in_mem [IN_DEPTH];
  logic [IPW-1:0]   r_in_wr, r_in_rd;
  logic [IPW-1:0]   w_in_wr_nxt, w_in_rd_nxt;
  logic             w_in_empty, w_in_full_nxt, w_push, w_issue;
  logic [EW-1:0]    w_in_head;
  logic [31:0]      w_head_a, w_head_b;
  logic             w_head_cmd;
  logic [TAG_W-1:0] w_head_tag;

  // Flight pipeline: stage 0 is the operand register, stage LAT the capture point
  logic [LAT:0]     r_v;
  logic [TAG_W-1:0] r_tag [LAT+1];
  logic [LAT:0]     w_v_nxt;
  logic [CW-1:0]    w_infl, w_used;
  logic             w_cap;
  logic [31:0]      w_cap_res;

  // Output FIFO
  logic [OW-1:0]    r_out_mem [OUT_DEPTH];
  logic [OPW-1:0]   r_out_wr, r_out_rd;
  logic [OPW-1:0]   w_out_cnt, w_out_remain, w_out_cnt_nxt, w_out_rd_nxt;
  logic             w_pop;
  logic [OW-1:0]    w_cap_data, w_head_nxt;

  logic             r_in_ready, r_out_valid, r_busy;
  logic [31:0]      r_fpu_a, r_fpu_b, r_out_result;
  logic             r_fpu_cmd;
  logic [TAG_W-1:0] r_out_tag;

  assign w_push      = in_valid & r_in_ready;
  assign w_in_empty  = (r_in_wr == r_in_rd);
  assign w_in_head   = r_in_mem[r_in_rd[IAW-1:0]];
  assign w_head_a    = w_in_head[EW-1 -: 32];
  assign w_head_b    = w_in_head[EW-33 -: 32];
  assign w_head_cmd  = w_in_head[TAG_W];
  assign w_head_tag  = w_in_head[TAG_W-1:0];

  // Credit check: a same-cycle pop is deliberately not counted as a free slot
  always_comb begin
    w_infl = '0;
    for (int i = 0; i <= int'(LAT); i++) w_infl = w_infl + CW'(r_v[i]);
  end
  assign w_used  = CW'(w_out_cnt) + w_infl;
  assign w_issue = !w_in_empty && (w_used < CW'(OUT_DEPTH));

  assign w_in_wr_nxt   = r_in_wr + IPW'(w_push);
  assign w_in_rd_nxt   = r_in_rd + IPW'(w_issue);
  assign w_in_full_nxt = (w_in_wr_nxt[IPW-1] != w_in_rd_nxt[IPW-1]) &&
                         (w_in_wr_nxt[IPW-2:0] == w_in_rd_nxt[IPW-2:0]);

  // Input FIFO storage (no reset needed, guarded by pointers)
  always_ff @(posedge clk) begin
    if (w_push) r_in_mem[r_in_wr[IAW-1:0]] <= {in_a, in_b, in_cmd, in_tag};
  end

  // Input pointers and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_wr    <= '0;
      r_in_rd    <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_in_wr    <= w_in_wr_nxt;
      r_in_rd    <= w_in_rd_nxt;
      r_in_ready <= !w_in_full_nxt;
    end
  end

  // Operand registers toward the adder; hold when not issuing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpu_a   <= '0;
      r_fpu_b   <= '0;
      r_fpu_cmd <= 1'b1;
    end else if (w_issue) begin
      r_fpu_a   <= w_head_a;
      r_fpu_b   <= w_head_b;
      r_fpu_cmd <= w_head_cmd;
    end
  end

  // Valid/tag shift register tracking ops inside the adder
  assign w_v_nxt = {r_v[LAT-1:0], w_issue};
  assign w_cap   = r_v[LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int i = 0; i <= int'(LAT); i++) r_tag[i] <= '0;
    end else begin
      r_v      <= w_v_nxt;
      r_tag[0] <= w_head_tag;
      for (int i = 1; i <= int'(LAT); i++) r_tag[i] <= r_tag[i-1];
    end
  end

`ifdef FP32_SPECIAL_BYPASS_EN
  logic        r_byp  [LAT+1];
  logic [31:0] r_bval [LAT+1];
  logic [32:0] w_class;

  // {bypass flag, bypass value}; NaN > Inf-Inf > A Inf > B Inf
  function automatic logic [32:0] classify(input logic [31:0] a, input logic [31:0] b,
                                           input logic cmd);
    logic nan_a, nan_b, inf_a, inf_b, eff_sub;
    nan_a   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nan_b   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    inf_a   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    inf_b   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    eff_sub = a[31] ^ b[31] ^ !cmd;
    classify = '0;
    if (nan_a || nan_b)               classify = {1'b1, 32'h7FC0_0000};
    else if (inf_a && inf_b && eff_sub) classify = {1'b1, 32'h7FC0_0000};
    else if (inf_a)                   classify = {1'b1, a};
    else if (inf_b)                   classify = {1'b1, b[31] ^ !cmd, b[30:0]};
  endfunction

  assign w_class = classify(w_head_a, w_head_b, w_head_cmd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= int'(LAT); i++) begin
        r_byp[i]  <= 1'b0;
        r_bval[i] <= '0;
      end
    end else begin
      r_byp[0]  <= w_class[32];
      r_bval[0] <= w_class[31:0];
      for (int i = 1; i <= int'(LAT); i++) begin
        r_byp[i]  <= r_byp[i-1];
        r_bval[i] <= r_bval[i-1];
      end
    end
  end

  assign w_cap_res = r_byp[LAT] ? r_bval[LAT] : fpu_result;
`else
  assign w_cap_res = fpu_result;
`endif

  assign w_cap_data    = {w_cap_res, r_tag[LAT]};
  assign w_pop         = r_out_valid & out_ready;
  assign w_out_cnt     = r_out_wr - r_out_rd;
  assign w_out_remain  = w_out_cnt - OPW'(w_pop);
  assign w_out_cnt_nxt = w_out_remain + OPW'(w_cap);
  assign w_out_rd_nxt  = r_out_rd + OPW'(w_pop);

  // Next head: bypass the write data when it lands in an otherwise empty FIFO
  always_comb begin
    w_head_nxt = {r_out_result, r_out_tag};
    if (w_out_cnt_nxt != '0) begin
      if (w_out_remain == '0) w_head_nxt = w_cap_data;
      else                    w_head_nxt = r_out_mem[w_out_rd_nxt[OAW-1:0]];
    end
  end

  // Output FIFO storage
  always_ff @(posedge clk) begin
    if (w_cap) r_out_mem[r_out_wr[OAW-1:0]] <= w_cap_data;
  end

  // Output pointers, registered head, valid and busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_wr     <= '0;
      r_out_rd     <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_out_wr     <= r_out_wr + OPW'(w_cap);
      r_out_rd     <= w_out_rd_nxt;
      r_out_valid  <= (w_out_cnt_nxt != '0);
      r_out_result <= w_head_nxt[OW-1 -: 32];
      r_out_tag    <= w_head_nxt[TAG_W-1:0];
      r_busy       <= (w_in_wr_nxt != w_in_rd_nxt) || (|w_v_nxt) || (w_out_cnt_nxt != '0);
    end
  end

  assign in_ready    = r_in_ready;
  assign fpu_add1    = r_fpu_a;
  assign fpu_add2    = r_fpu_b;
  assign fpu_command = r_fpu_cmd;
  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_tag     = r_out_tag;
  assign busy        = r_busy;

endmodule

// File: tb/tb_fp32_addsub_issue.sv
// Directed bench for fp32_addsub_issue with a table-driven stand-in for the
// registered FP32 adder (1-cycle latency, no reset).
module tb_fp32_addsub_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_cmd;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic [31:0] fpu_add1, fpu_add2, fpu_result;
  logic        fpu_command;
  logic        out_valid, out_ready, busy;
  logic [31:0] out_result;
  logic [3:0]  out_tag;

  int checks   = 0;
  int failures = 0;

  // Hand-computed single-precision vectors: a op b = r
  logic [31:0] va [10];
  logic [31:0] vb [10];
  logic        vc [10];
  logic [31:0] vr [10];

  fp32_addsub_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cmd(in_cmd), .in_tag(in_tag),
    .fpu_add1(fpu_add1), .fpu_add2(fpu_add2), .fpu_command(fpu_command),
    .fpu_result(fpu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic c);
    adder_model = a ^ b;
    for (int i = 0; i < 10; i++)
      if (va[i] == a && vb[i] == b && vc[i] == c) adder_model = vr[i];
  endfunction

  always @(posedge clk) fpu_result <= adder_model(fpu_add1, fpu_add2, fpu_command);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one op and hold it until accepted (bounded)
  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic [3:0] t, output bit ok);
    bit r;
    in_a = a; in_b = b; in_cmd = c; in_tag = t; in_valid = 1'b1; ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      r = in_ready;
      step();
      if (r) ok = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (out_valid) ok = 1'b1;
      else step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cmd = 1'b0; in_tag = '0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (fpu_add1 !== 32'h0 || fpu_add2 !== 32'h0 || fpu_command !== 1'b1) begin
      failures++; $display("FAIL reset_fpu_regs: got %h %h %b expected 0 0 1", fpu_add1, fpu_add2, fpu_command); end
    checks++; if (out_result !== 32'h0 || out_tag !== 4'h0) begin
      failures++; $display("FAIL reset_out_data: got %h/%h expected 0/0", out_result, out_tag); end
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add();
    bit ok;
    out_ready = 1'b1;
    send_one(32'h3F80_0000, 32'h4000_0000, 1'b1, 4'd5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL add_accept: got timeout expected accept"); end
    step();
    checks++; if (fpu_add1 !== 32'h3F80_0000 || fpu_add2 !== 32'h4000_0000 || fpu_command !== 1'b1) begin
      failures++; $display("FAIL add_issue: got %h %h %b expected 3f800000 40000000 1", fpu_add1, fpu_add2, fpu_command); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_early1: got %b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_early2: got %b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid_lat3: got %b expected 1", out_valid); end
    checks++; if (out_result !== 32'h4040_0000 || out_tag !== 4'd5) begin
      failures++; $display("FAIL add_result: got %h/%h expected 40400000/5", out_result, out_tag); end
    step();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL add_pop: got valid=%b busy=%b expected 0 0", out_valid, busy); end
  endtask

  task automatic test_sub();
    bit ok;
    out_ready = 1'b1;
    send_one(32'h4040_0000, 32'h3F80_0000, 1'b0, 4'd9, ok);
    wait_out(ok);
    checks++; if (!ok) begin failures++; $display("FAIL sub_wait: got timeout expected out_valid"); end
    checks++; if (out_result !== 32'h4000_0000 || out_tag !== 4'd9) begin
      failures++; $display("FAIL sub_result: got %h/%h expected 40000000/9", out_result, out_tag); end
    step();
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, first = -1, last = -1;
    bit r;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (out_valid) begin
        checks++; if (out_result !== vr[got] || out_tag !== 4'(got)) begin
          failures++; $display("FAIL b2b_result%0d: got %h/%h expected %h/%h", got, out_result, out_tag, vr[got], 4'(got)); end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (sent < 8) begin
        in_valid = 1'b1; in_a = va[sent]; in_b = vb[sent]; in_cmd = vc[sent]; in_tag = 4'(sent);
        r = in_ready;
        checks++; if (r !== 1'b1) begin failures++; $display("FAIL b2b_in_ready: got %b expected 1", r); end
      end else begin
        in_valid = 1'b0; r = 1'b0;
      end
      step();
      if (r) sent++;
    end
    in_valid = 1'b0;
    checks++; if (got != 8 || last - first != 7) begin
      failures++; $display("FAIL b2b_rate: got %0d results over %0d cycles expected 8 over 7", got, last - first); end
    step();
  endtask

  task automatic test_backpressure();
    int acc = 0, got = 0;
    bit r;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = 1'b1; in_a = va[acc]; in_b = vb[acc]; in_cmd = vc[acc]; in_tag = 4'(acc);
      r = in_ready;
      step();
      if (r) acc++;
    end
    checks++; if (acc != 8) begin failures++; $display("FAIL bp_accepted: got %0d expected 8", acc); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_result !== vr[0] || out_tag !== 4'd0) begin
      failures++; $display("FAIL bp_head: got %b %h/%h expected 1 %h/0", out_valid, out_result, out_tag, vr[0]); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      if (out_valid) begin
        checks++; if (out_result !== vr[got] || out_tag !== 4'(got)) begin
          failures++; $display("FAIL bp_result%0d: got %h/%h expected %h/%h", got, out_result, out_tag, vr[got], 4'(got)); end
        got++;
      end
      if (acc < 10) begin
        in_valid = 1'b1; in_a = va[acc]; in_b = vb[acc]; in_cmd = vc[acc]; in_tag = 4'(acc);
        r = in_ready;
      end else begin
        in_valid = 1'b0; r = 1'b0;
      end
      step();
      if (r) acc++;
    end
    in_valid = 1'b0;
    checks++; if (got != 10 || acc != 10) begin
      failures++; $display("FAIL bp_drain: got %0d results %0d accepted expected 10 10", got, acc); end
    step();
  endtask

  task automatic test_simul_push_pop();
    int acc = 0, got = 0;
    bit r;
    for (int cyc = 0; cyc < 120 && got < 12; cyc++) begin
      out_ready = cyc[0];
      if (out_valid && out_ready) begin
        checks++; if (out_result !== vr[got % 10] || out_tag !== 4'(got)) begin
          failures++; $display("FAIL pp_result%0d: got %h/%h expected %h/%h", got, out_result, out_tag, vr[got % 10], 4'(got)); end
        got++;
      end
      if (acc < 12) begin
        in_valid = 1'b1; in_a = va[acc % 10]; in_b = vb[acc % 10]; in_cmd = vc[acc % 10]; in_tag = 4'(acc);
        r = in_ready;
      end else begin
        in_valid = 1'b0; r = 1'b0;
      end
      step();
      if (r) acc++;
    end
    in_valid = 1'b0;
    checks++; if (got != 12) begin failures++; $display("FAIL pp_count: got %0d expected 12", got); end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL pp_idle: got busy=%b valid=%b expected 0 0", busy, out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    bit r, seen;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 20 && acc < 4; cyc++) begin
      in_valid = 1'b1; in_a = va[acc]; in_b = vb[acc]; in_cmd = vc[acc]; in_tag = 4'(acc);
      r = in_ready;
      step();
      if (r) acc++;
    end
    in_valid = 1'b0;
    step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rm_busy_before: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL rm_async: got valid=%b ready=%b expected 0 0", out_valid, in_ready); end
    step(); step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rm_stale: got result after reset expected none"); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL rm_idle: got ready=%b busy=%b expected 1 0", in_ready, busy); end
  endtask

`ifdef FP32_SPECIAL_BYPASS_EN
  task automatic test_bypass();
    bit ok;
    out_ready = 1'b1;
    send_one(32'h7F80_0000, 32'h7F80_0000, 1'b0, 4'd1, ok);
    wait_out(ok);
    checks++; if (!ok || out_result !== 32'h7FC0_0000) begin
      failures++; $display("FAIL byp_inf_sub: got %h expected 7fc00000", out_result); end
    step();
    send_one(32'h7FC0_0001, 32'h3F80_0000, 1'b1, 4'd2, ok);
    wait_out(ok);
    checks++; if (!ok || out_result !== 32'h7FC0_0000) begin
      failures++; $display("FAIL byp_nan: got %h expected 7fc00000", out_result); end
    step();
    send_one(32'h3F80_0000, 32'hFF80_0000, 1'b0, 4'd3, ok);
    wait_out(ok);
    checks++; if (!ok || out_result !== 32'h7F80_0000) begin
      failures++; $display("FAIL byp_b_inf: got %h expected 7f800000", out_result); end
    step();
  endtask
`endif

  initial begin
    va[0] = 32'h3F80_0000; vb[0] = 32'h4000_0000; vc[0] = 1'b1; vr[0] = 32'h4040_0000; // 1+2=3
    va[1] = 32'h4040_0000; vb[1] = 32'h3F80_0000; vc[1] = 1'b0; vr[1] = 32'h4000_0000; // 3-1=2
    va[2] = 32'h3F80_0000; vb[2] = 32'h3F80_0000; vc[2] = 1'b1; vr[2] = 32'h4000_0000; // 1+1=2
    va[3] = 32'h4000_0000; vb[3] = 32'h4000_0000; vc[3] = 1'b1; vr[3] = 32'h4080_0000; // 2+2=4
    va[4] = 32'h4080_0000; vb[4] = 32'h3F80_0000; vc[4] = 1'b0; vr[4] = 32'h4040_0000; // 4-1=3
    va[5] = 32'h4040_0000; vb[5] = 32'h3F80_0000; vc[5] = 1'b1; vr[5] = 32'h4080_0000; // 3+1=4
    va[6] = 32'h4000_0000; vb[6] = 32'h4000_0000; vc[6] = 1'b0; vr[6] = 32'h0000_0000; // 2-2=0
    va[7] = 32'h3F00_0000; vb[7] = 32'h3F00_0000; vc[7] = 1'b1; vr[7] = 32'h3F80_0000; // .5+.5=1
    va[8] = 32'h4100_0000; vb[8] = 32'h4080_0000; vc[8] = 1'b0; vr[8] = 32'h4080_0000; // 8-4=4
    va[9] = 32'h3F80_0000; vb[9] = 32'h4080_0000; vc[9] = 1'b1; vr[9] = 32'h40A0_0000; // 1+4=5
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_simul_push_pop();
    test_reset_mid();
`ifdef FP32_SPECIAL_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
